sd_cmd_host_v2: RTL and testbench

//  Next-generation SD CMD-line host engine. Serialises a 40-bit command plus CRC7 and end bit onto CMD.

---
 rtl/sd_cmd_host_v2_pkg.sv | 29 ++
 rtl/sd_cmd_host_v2_crc7.sv | 35 +++
 rtl/sd_cmd_host_v2.sv | 229 ++++++++++++++++++++++
 tb/tb_sd_cmd_host_v2.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_host_v2_pkg.sv
// Shared definitions for the SD CMD-line host engine: FSM state encodings,
// response-length codes and status bit positions.
package sd_cmd_host_v2_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_SEND,
      ST_NCR_WAIT,
      ST_RECV,
      ST_BUSY,
      ST_NCC,
      ST_DONE
   } state_e;

   localparam logic [1:0] RESP_NONE = 2'b00;
   localparam logic [1:0] RESP_48   = 2'b01;
   localparam logic [1:0] RESP_136  = 2'b10;

   localparam int STAT_TIMEOUT = 0;
   localparam int STAT_CRC     = 1;
   localparam int STAT_END     = 2;
   localparam int STAT_BUSY    = 3;

   localparam int CMD_BITS   = 48;
   localparam int NCR_IGNORE = 2;  // CMD input cycles discarded after turnaround
   localparam int BUSY_SKIP  = 1;  // DAT0 is first sampled two cycles after the last CMD bit

endpackage

// File: rtl/sd_cmd_host_v2_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, MSB first.
// Clear has priority over update so a phase can restart the remainder in one cycle.
module sd_crc_7 (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       din_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q, crc_d;
   logic       fb;

   assign fb    = din_i ^ crc_q[6];
   assign crc_o = crc_q;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = '0;
      end else if (en_i) begin
         crc_d = {crc_q[5:0], fb} ^ {3'b000, fb, 3'b000};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

endmodule

// File: rtl/sd_cmd_host_v2.sv
// SD CMD-line host engine: sends a 48-bit command with CRC7, captures a 48/136-bit
// response, checks CRC/end bit/NCR timeout, optionally waits out R1b busy on DAT0.
//
// state     | meaning
// ----------+----------------------------------------------------------
// INIT      | power-up clocks with CMD driven high, not ready
// IDLE      | ready for a command, CMD released
// SEND      | 48 command bits: arg, CRC7, end bit
// NCR_WAIT  | waiting for response start bit (bounded by NCR_MAX)
// RECV      | shifting in the remaining response bits
// BUSY      | R1b: waiting for DAT0 to go high (bounded)
// NCC       | idle gap before the next command
// DONE      | one-cycle completion pulse
module sd_cmd_host_v2
   import sd_cmd_host_v2_pkg::*;
#(
   parameter int INIT_CLKS = 74,
   parameter int NCR_MAX   = 64,
   parameter int NCC_CLKS  = 8,
   parameter int BUSY_TO_W = 20
) (
   input  logic         SD_CLK_IN,
   input  logic         RST_N_IN,
   input  logic         cmd_valid_i,
   output logic         cmd_ready_o,
   input  logic [39:0]  cmd_arg_i,
   input  logic [1:0]   cmd_resp_len_i,
   input  logic         cmd_crc_chk_i,
   input  logic         cmd_busy_i,
   output logic         resp_valid_o,
   output logic [126:0] resp_data_o,
   output logic [3:0]   resp_status_o,
   input  logic         cmd_dat_i,
   output logic         cmd_out_o,
   output logic         cmd_oe_o,
   input  logic         dat0_i
);

   state_e                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [BUSY_TO_W-1:0]   bcnt_q, bcnt_d;
   logic [39:0]            tx_q, tx_d;
   // Frame bits above 127 are never reported, so they are allowed to fall off the top.
   logic [126:0]           rx_q, rx_d;
   logic [1:0]             len_q, len_d;
   logic                   chk_q, chk_d;
   logic                   busy_q, busy_d;
   logic [126:0]           data_q, data_d;
   logic [3:0]             stat_q, stat_d;

   logic                   crc_clr, crc_en, crc_din;
   logic [6:0]             crc;
   logic [2:0]             crc_idx;
   logic                   after_cmd;
   logic                   is_136;

   assign crc_idx       = cnt_q[2:0] - 3'd1;
   assign is_136        = (len_q == RESP_136);
   assign resp_data_o   = data_q;
   assign resp_status_o = stat_q;

   sd_crc_7 u_crc (
      .clk_i   (SD_CLK_IN),
      .rst_n_i (RST_N_IN),
      .clr_i   (crc_clr),
      .en_i    (crc_en),
      .din_i   (crc_din),
      .crc_o   (crc)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bcnt_d       = bcnt_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      len_d        = len_q;
      chk_d        = chk_q;
      busy_d       = busy_q;
      data_d       = data_q;
      stat_d       = stat_q;
      crc_clr      = 1'b0;
      crc_en       = 1'b0;
      crc_din      = 1'b0;
      after_cmd    = 1'b0;
      cmd_ready_o  = 1'b0;
      cmd_oe_o     = 1'b0;
      cmd_out_o    = 1'b1;
      resp_valid_o = 1'b0;

      case (state_q)
         ST_INIT: begin
            cmd_oe_o = 1'b1;
            if (cnt_q == 8'd0) state_d = ST_IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               state_d = ST_SEND;
               tx_d    = cmd_arg_i;
               len_d   = cmd_resp_len_i;
               chk_d   = cmd_crc_chk_i;
               busy_d  = cmd_busy_i;
               stat_d  = '0;
               data_d  = '0;
               cnt_d   = 8'(CMD_BITS - 1);
               crc_clr = 1'b1;
            end
         end
         ST_SEND: begin
            cmd_oe_o = 1'b1;
            if (cnt_q >= 8'd8) begin
               cmd_out_o = tx_q[39];
               crc_en    = 1'b1;
               crc_din   = tx_q[39];
               tx_d      = {tx_q[38:0], 1'b0};
            end else if (cnt_q != 8'd0) begin
               cmd_out_o = crc[crc_idx];
            end
            if (cnt_q == 8'd0) begin
               crc_clr = 1'b1;
               if (len_q != RESP_NONE) begin
                  state_d = ST_NCR_WAIT;
                  cnt_d   = 8'(NCR_MAX - 1);
               end else begin
                  after_cmd = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_NCR_WAIT: begin
            if (cnt_q < 8'(NCR_MAX - NCR_IGNORE) && !cmd_dat_i) begin
               state_d = ST_RECV;
               rx_d    = {rx_q[125:0], 1'b0};
               // The R2 start bit lies outside its CRC coverage.
               crc_en  = !is_136;
               cnt_d   = is_136 ? 8'd134 : 8'd46;
            end else if (cnt_q == 8'd0) begin
               stat_d[STAT_TIMEOUT] = 1'b1;
               state_d = ST_NCC;
               cnt_d   = 8'(NCC_CLKS - 1);
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RECV: begin
            rx_d = {rx_q[125:0], cmd_dat_i};
            if (cnt_q >= 8'd8 && cnt_q <= 8'd127) begin
               crc_en  = 1'b1;
               crc_din = cmd_dat_i;
            end
            if (cnt_q == 8'd0) begin
               if (chk_q && (crc != rx_q[6:0])) stat_d[STAT_CRC] = 1'b1;
               if (!cmd_dat_i)                  stat_d[STAT_END] = 1'b1;
               data_d    = is_136 ? rx_q : {89'b0, rx_q[44:7]};
               after_cmd = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else if (dat0_i) begin
               state_d = ST_NCC;
               cnt_d   = 8'(NCC_CLKS - 1);
            end else if (bcnt_q == '0) begin
               stat_d[STAT_BUSY] = 1'b1;
               state_d = ST_NCC;
               cnt_d   = 8'(NCC_CLKS - 1);
            end else begin
               bcnt_d = bcnt_q - 1'b1;
            end
         end
         ST_NCC: begin
            if (cnt_q == 8'd0) state_d = ST_DONE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         ST_DONE: begin
            resp_valid_o = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = 8'(INIT_CLKS - 1);
         end
      endcase

      if (after_cmd) begin
         if (busy_q) begin
            state_d = ST_BUSY;
            cnt_d   = 8'(BUSY_SKIP);
            bcnt_d  = '1;
         end else begin
            state_d = ST_NCC;
            cnt_d   = 8'(NCC_CLKS - 1);
         end
      end
   end

   always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         state_q <= ST_INIT;
         cnt_q   <= 8'(INIT_CLKS - 1);
         bcnt_q  <= '1;
         tx_q    <= '0;
         rx_q    <= '0;
         len_q   <= RESP_NONE;
         chk_q   <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         stat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         len_q   <= len_d;
         chk_q   <= chk_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         stat_q  <= stat_d;
      end
   end

endmodule

// File: tb/tb_sd_cmd_host_v2.sv
// Scoreboard bench for sd_cmd_host_v2: directed commands with hand-computed frames,
// a card model driving responses, and monitors checking TX frames and completions.
module tb_sd_cmd_host_v2;

   localparam int BTW = 11;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid_i = 1'b0;
   logic         cmd_ready_o;
   logic [39:0]  cmd_arg_i = '0;
   logic [1:0]   cmd_resp_len_i = '0;
   logic         cmd_crc_chk_i = 1'b0;
   logic         cmd_busy_i = 1'b0;
   logic         resp_valid_o;
   logic [126:0] resp_data_o;
   logic [3:0]   resp_status_o;
   logic         cmd_dat_i = 1'b1;
   logic         cmd_out_o;
   logic         cmd_oe_o;
   logic         dat0_i = 1'b1;

   sd_cmd_host_v2 #(.INIT_CLKS(74), .NCR_MAX(64), .NCC_CLKS(8), .BUSY_TO_W(BTW)) dut (
      .SD_CLK_IN      (clk),
      .RST_N_IN       (rst_n),
      .cmd_valid_i    (cmd_valid_i),
      .cmd_ready_o    (cmd_ready_o),
      .cmd_arg_i      (cmd_arg_i),
      .cmd_resp_len_i (cmd_resp_len_i),
      .cmd_crc_chk_i  (cmd_crc_chk_i),
      .cmd_busy_i     (cmd_busy_i),
      .resp_valid_o   (resp_valid_o),
      .resp_data_o    (resp_data_o),
      .resp_status_o  (resp_status_o),
      .cmd_dat_i      (cmd_dat_i),
      .cmd_out_o      (cmd_out_o),
      .cmd_oe_o       (cmd_oe_o),
      .dat0_i         (dat0_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [126:0] data;
      logic [3:0]   status;
      int           lat;
      string        name;
   } exp_t;

   exp_t        rq[$];
   logic [47:0] txq[$];
   int          checks = 0;
   int          errors = 0;
   int          n_resp = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   exp_t        mon_e;
   logic [47:0] txm_e, txm_g;
   int          txm_bad;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // TX monitor: on every accept, capture the 48 serial bits and compare with the queued frame.
   always @(negedge clk) begin
      if (rst_n && cmd_valid_i && cmd_ready_o) begin
         acc_cyc = cyc;
         if (txq.size() > 0) begin
            txm_e   = txq.pop_front();
            txm_bad = 0;
            for (int i = 47; i >= 0; i--) begin
               @(negedge clk);
               txm_g[i] = cmd_out_o;
               if (!cmd_oe_o) txm_bad++;
            end
            chk("tx_frame", {80'b0, txm_g}, {80'b0, txm_e});
            chk("tx_oe_low_cycles", 128'(txm_bad), 128'd0);
         end
      end
   end

   // Response monitor: pops the scoreboard on each completion pulse.
   always @(negedge clk) begin
      if (rst_n && resp_valid_o) begin
         n_resp++;
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got status %0h data %0h, expected no response",
                     resp_status_o, resp_data_o);
         end else begin
            mon_e = rq.pop_front();
            chk({mon_e.name, "_data"}, {1'b0, resp_data_o}, {1'b0, mon_e.data});
            chk({mon_e.name, "_status"}, 128'(resp_status_o), 128'(mon_e.status));
            if (mon_e.lat >= 0) chk({mon_e.name, "_latency"}, 128'(cyc - acc_cyc), 128'(mon_e.lat));
         end
      end
   end

   task automatic expect_resp(input logic [126:0] d, input logic [3:0] s, input int lat,
                              input string nm);
      exp_t e;
      e.data = d; e.status = s; e.lat = lat; e.name = nm;
      rq.push_back(e);
   endtask

   task automatic issue(input logic [39:0] arg, input logic [1:0] len, input logic crc_chk,
                        input logic busy);
      int n;
      @(posedge clk); #1;
      cmd_arg_i = arg; cmd_resp_len_i = len; cmd_crc_chk_i = crc_chk; cmd_busy_i = busy;
      cmd_valid_i = 1'b1;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (cmd_ready_o) break;
      end
      if (n == 300) begin
         checks++; errors++;
         $display("FAIL issue_timeout: got ready=0 for 300 clks, expected ready=1");
      end
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_oe_fall();
      int n;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!cmd_oe_o) break;
      end
      if (n == 200) begin
         checks++; errors++;
         $display("FAIL oe_fall_timeout: got oe=1 for 200 clks, expected oe=0");
      end
   endtask

   task automatic card(input logic [135:0] f, input int nbits, input int dly);
      wait_oe_fall();
      repeat (dly) @(posedge clk);
      #1;
      for (int i = nbits - 1; i >= 0; i--) begin
         cmd_dat_i = f[i];
         @(posedge clk); #1;
      end
      cmd_dat_i = 1'b1;
   endtask

   task automatic wait_resp(input int target, input int budget);
      int n;
      for (n = 0; n < budget; n++) begin
         if (n_resp >= target) break;
         @(negedge clk);
      end
      if (n_resp < target) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got %0d responses, expected %0d", n_resp, target);
      end
   endtask

   task automatic measure_init(input string nm);
      int n, bad;
      n = 0; bad = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (cmd_ready_o) break;
         if (!(cmd_oe_o && cmd_out_o)) bad++;
      end
      chk({nm, "_init_clks"}, 128'(n), 128'd74);
      chk({nm, "_init_pins"}, 128'(bad), 128'd0);
      chk({nm, "_idle_oe"}, 128'(cmd_oe_o), 128'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish by 5ms, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [135:0] r2;
      logic [127:0] r2_low;
      int tgt;

      #2;
      chk("rst_ready", 128'(cmd_ready_o), 128'd0);
      chk("rst_oe", 128'(cmd_oe_o), 128'd1);
      chk("rst_out", 128'(cmd_out_o), 128'd1);
      chk("rst_valid", 128'(resp_valid_o), 128'd0);
      chk("rst_data", {1'b0, resp_data_o}, 128'd0);
      chk("rst_status", 128'(resp_status_o), 128'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      measure_init("por");
      tgt = 0;

      // CMD0, no response; extra valid during the transfer must be ignored.
      txq.push_back(48'h400000000095);
      expect_resp('0, 4'b0000, 57, "cmd0");
      issue(40'h4000000000, 2'b00, 1'b0, 1'b0);
      cmd_arg_i = 40'h7700000000; cmd_valid_i = 1'b1;
      repeat (5) @(posedge clk);
      #1 cmd_valid_i = 1'b0;
      wait_resp(++tgt, 300);

      // CMD8 with correct R7
      txq.push_back(48'h48000001AA87);
      expect_resp(127'h08000001AA, 4'b0000, 110, "cmd8_ok");
      issue(40'h48000001AA, 2'b01, 1'b1, 1'b0);
      card(136'h08000001AA13, 48, 5);
      wait_resp(++tgt, 300);

      // CRC7 field 0x12 instead of 0x09
      txq.push_back(48'h48000001AA87);
      expect_resp(127'h08000001AA, 4'b0010, 110, "cmd8_crcerr");
      issue(40'h48000001AA, 2'b01, 1'b1, 1'b0);
      card(136'h08000001AA25, 48, 5);
      wait_resp(++tgt, 300);

      // Same bad CRC, checking disabled, length code 11 behaves as 48-bit
      txq.push_back(48'h48000001AA87);
      expect_resp(127'h08000001AA, 4'b0000, 110, "cmd8_nochk");
      issue(40'h48000001AA, 2'b11, 1'b0, 1'b0);
      card(136'h08000001AA25, 48, 5);
      wait_resp(++tgt, 300);

      // Good CRC, end bit 0
      txq.push_back(48'h48000001AA87);
      expect_resp(127'h08000001AA, 4'b0100, 110, "cmd8_enderr");
      issue(40'h48000001AA, 2'b01, 1'b1, 1'b0);
      card(136'h08000001AA12, 48, 5);
      wait_resp(++tgt, 300);

      // CMD55, no reply: NCR timeout, busy requested but skipped
      txq.push_back(48'h770000000065);
      expect_resp('0, 4'b0001, 121, "ncr_timeout");
      issue(40'h7700000000, 2'b01, 1'b1, 1'b1);
      wait_resp(++tgt, 400);

      // CMD2 with 136-bit reply
      r2     = {8'h3F, 128'h0123456789ABCDEFFEDCBA9876543211};
      r2_low = r2[127:0];
      txq.push_back(48'h42000000004D);
      expect_resp(r2_low[127:1], 4'b0000, 198, "cmd2_r2");
      issue(40'h4200000000, 2'b10, 1'b0, 1'b0);
      card(r2, 136, 5);
      wait_resp(++tgt, 400);

      // R1b busy released after 1000 clks
      dat0_i = 1'b0;
      txq.push_back(48'h400000000095);
      expect_resp('0, 4'b0000, 1058, "busy_release");
      issue(40'h4000000000, 2'b00, 1'b0, 1'b1);
      wait_oe_fall();
      repeat (1000) @(posedge clk);
      #1 dat0_i = 1'b1;
      wait_resp(++tgt, 200);

      // R1b with DAT0 stuck low
      dat0_i = 1'b0;
      txq.push_back(48'h400000000095);
      expect_resp('0, 4'b1000, 48 + 2 + (2**BTW - 1) + 1 + 8, "busy_timeout");
      issue(40'h4000000000, 2'b00, 1'b0, 1'b1);
      wait_resp(++tgt, 2600);
      dat0_i = 1'b1;

      // Reset during SEND: pads go high immediately, INIT restarts, no completion
      issue(40'h4000000000, 2'b00, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_oe", 128'(cmd_oe_o), 128'd1);
      chk("midrst_out", 128'(cmd_out_o), 128'd1);
      chk("midrst_ready", 128'(cmd_ready_o), 128'd0);
      chk("midrst_status", 128'(resp_status_o), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      measure_init("midrst");

      txq.push_back(48'h400000000095);
      expect_resp('0, 4'b0000, 57, "cmd0_after_rst");
      issue(40'h4000000000, 2'b00, 1'b0, 1'b0);
      wait_resp(++tgt, 300);

      repeat (20) @(negedge clk);
      chk("resp_queue_left", 128'(rq.size()), 128'd0);
      chk("tx_queue_left", 128'(txq.size()), 128'd0);
      chk("resp_count", 128'(n_resp), 128'(tgt));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
